// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port main-memory arbiter: FSM states, port ids, op codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_IF) ? PORT_D : PORT_IF;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; bit index of req/grant is the port id.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = (other_port(last_grant) == PORT_D) ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between the fetch port and the data port,
// sequencing mem_rd/mem_wr and returning read data with a one-cycle ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  op_t               op, op_nxt;
  port_t             owner, owner_nxt;
  port_t             last_grant, last_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
  logic              mem_rd_nxt, mem_wr_nxt;
  logic              if_ack_nxt, d_ack_nxt;
  logic              busy_nxt;
  logic [1:0]        grant_c;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, if_req}),
    .last_grant (last_grant),
    .grant_c    (grant_c)
  );

  // State and registered outputs; reset returns to IDLE with every output low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= OP_RD;
      owner      <= PORT_IF;
      last_grant <= PORT_IF;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      op         <= op_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      mem_rd     <= mem_rd_nxt;
      mem_wr     <= mem_wr_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_ack     <= if_ack_nxt;
      d_ack      <= d_ack_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state and next-output decode; strobes are computed one cycle ahead.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    op_nxt       = op;
    owner_nxt    = owner;
    last_nxt     = last_grant;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    mem_rd_nxt   = 1'b0;
    mem_wr_nxt   = 1'b0;
    if_ack_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (grant_c[1]) begin
          owner_nxt = PORT_D;
          last_nxt  = PORT_D;
          addr_nxt  = d_addr;
          wdata_nxt = d_wdata;
          op_nxt    = d_we ? OP_WR : OP_RD;
          state_nxt = ISSUE;
        end else if (grant_c[0]) begin
          owner_nxt = PORT_IF;
          last_nxt  = PORT_IF;
          addr_nxt  = if_addr;
          op_nxt    = OP_RD;
          state_nxt = ISSUE;
        end
        if (state_nxt == ISSUE) begin
          mem_rd_nxt = (op_nxt == OP_RD);
          mem_wr_nxt = (op_nxt == OP_WR);
        end
      end
      ISSUE: begin
        if (op == OP_WR) begin
          state_nxt = ACK;
          d_ack_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = ACK;
          if (owner == PORT_D) begin
            d_rdata_nxt = mem_rdata;
            d_ack_nxt   = 1'b1;
          end else begin
            if_rdata_nxt = mem_rdata;
            if_ack_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push expected acks,
// a negedge monitor pops and compares; a second instance runs with MEM_RD_LAT=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // LAT=1 instance
  logic        if_req, if_ack, d_req, d_we, d_ack, mem_rd, mem_wr, busy;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  // LAT=3 instance
  logic        if_req3, if_ack3, d_ack3, mem_rd3, mem_wr3, busy3;
  logic [15:0] if_addr3, if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  typedef struct {
    logic        port;
    logic [15:0] ifd;
    logic [15:0] dd;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] mem1 [logic [15:0]];
  logic [15:0] smem [logic [15:0]];
  logic [15:0] p3 [3];
  logic [15:0] m_if, m_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rd(mem_rd3), .mem_wr(mem_wr3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hBEFF;
  endfunction

  function automatic logic [15:0] peek1(input logic [15:0] a);
    return mem1.exists(a) ? mem1[a] : init_val(a);
  endfunction

  function automatic logic [15:0] mval(input logic [15:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction

  // Memory device models; rdata is junk except in the cycles it is valid.
  always @(posedge clk) begin
    if (mem_wr) mem1[mem_addr] = mem_wdata;
    mem_rdata <= mem_rd ? peek1(mem_addr) : 16'hDEAD;
  end

  always @(posedge clk) begin
    p3[0] <= mem_rd3 ? init_val(mem_addr3) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
    if (if_ack || d_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({if_ack, d_ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", 32'({if_ack, d_ack}), e.port ? 32'd1 : 32'd2);
        check("ack_cycle", cyc, e.cyc);
        check("if_rdata", 32'(if_rdata), 32'(e.ifd));
        check("d_rdata", 32'(d_rdata), 32'(e.dd));
      end
    end
  end

  task automatic txn(input logic port, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata);
    int unsigned k;
    int n;
    @(posedge clk); #1;
    k = cyc;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    if (we) smem[addr] = wdata;
    else if (port) m_d = mval(addr);
    else m_if = mval(addr);
    sb.push_back('{port, m_if, m_d, k + (we ? 32'd2 : 32'd3)});
    @(negedge clk);
    @(negedge clk);
    check("issue_rd", 32'(mem_rd), 32'(!we));
    check("issue_wr", 32'(mem_wr), 32'(we));
    check("issue_addr", 32'(mem_addr), 32'(addr));
    if (we) check("issue_wdata", 32'(mem_wdata), 32'(wdata));
    @(negedge clk);
    check("strobe_one_cycle", 32'({mem_rd, mem_wr}), 32'd0);
    check("busy_mid", 32'(busy), 32'd1);
    n = 0;
    while (!(port ? d_ack : if_ack) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check("ack_timeout", 32'(port ? d_ack : if_ack), 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_if = '0; m_d = '0;
  endtask

  initial begin
    int unsigned k;
    int unsigned ack_cyc;
    int unsigned rd_cnt;
    logic [15:0] ack_data;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0;
    m_if = '0; m_d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({if_ack, d_ack, mem_rd, mem_wr}), 32'd0);
    check("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    check("rst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    rst = 1'b0;

    // Fetch read, then data write and readback.
    txn(1'b0, 1'b0, 16'h0010, 16'h0000);
    txn(1'b1, 1'b1, 16'h1234, 16'hA5A5);
    txn(1'b1, 1'b0, 16'h1234, 16'h0000);

    // Both ports held after reset: grants alternate D, IF, D, IF.
    pulse_reset();
    @(posedge clk); #1;
    k = cyc;
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1234;
    m_d = mval(16'h1234); sb.push_back('{1'b1, m_if, m_d, k + 3});
    m_if = mval(16'h0020); sb.push_back('{1'b0, m_if, m_d, k + 7});
    sb.push_back('{1'b1, m_if, m_d, k + 11});
    sb.push_back('{1'b0, m_if, m_d, k + 15});
    repeat (16) @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;

    // Fetch request held through ack: back-to-back reads every 4 cycles.
    @(posedge clk); #1;
    k = cyc;
    if_req = 1'b1; if_addr = 16'h0010;
    m_if = mval(16'h0010);
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, m_if, m_d, k + 3 + 4 * i});
    repeat (12) @(posedge clk);
    #1;
    if_req = 1'b0;

    // Reset during WAIT of a read: no ack, everything low immediately.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0030;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_outs", 32'({if_ack, d_ack, mem_rd, mem_wr}), 32'd0);
    check("midrst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    check("midrst_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_if = '0; m_d = '0;
    repeat (4) @(posedge clk);
    txn(1'b0, 1'b0, 16'h0040, 16'h0000);

    // MEM_RD_LAT=3 instance: ack five cycles after the request is seen.
    @(posedge clk); #1;
    k = cyc;
    ack_cyc = 0; ack_data = '0; rd_cnt = 0;
    if_req3 = 1'b1; if_addr3 = 16'h0050;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_rd3) rd_cnt++;
      if (if_ack3 && ack_cyc == 0) begin
        ack_cyc = cyc;
        ack_data = if_rdata3;
      end
    end
    @(posedge clk); #1;
    if_req3 = 1'b0;
    check("lat3_ack_cycle", ack_cyc, k + 5);
    check("lat3_rdata", 32'(ack_data), 32'(init_val(16'h0050)));
    check("lat3_rd_pulses", rd_cnt, 32'd1);
    check("lat3_dport_idle", 32'({d_ack3, mem_wr3, d_rdata3, mem_wdata3}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("lat3_busy_end", 32'(busy3), 32'd0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
